// File: rtl/fetch_issue_queue_pkg.sv
// Shared decode-stage package: width parameters, queue entry layout,
// downstream format one-hot constants and a slot address helper.
// Ports: none (package).
package fetch_issue_queue_pkg;

    localparam int unsigned addressWidth            = 64;
    localparam int unsigned instructionWidth        = 32;
    localparam int unsigned PidSize                 = 20;
    localparam int unsigned TidSize                 = 16;
    localparam int unsigned instructionCounterWidth = 64;
    localparam int unsigned opcodeSize              = 6;
    localparam int unsigned fetchBlockSize          = 4;
    localparam int unsigned queueDepth              = 16;
    localparam int unsigned ptrWidth                = $clog2(queueDepth);
    localparam int unsigned countWidth              = ptrWidth + 1;
    localparam int unsigned fetchBlockWidth         = fetchBlockSize * instructionWidth;

    // One entry of the issue queue, one instruction of a fetch block.
    typedef struct packed {
        logic [instructionWidth-1:0] instruction;
        logic [addressWidth-1:0]     address;
        logic [PidSize-1:0]          pid;
        logic [TidSize-1:0]          tid;
    } queueEntry_t;

    // Instruction format one-hot codes consumed by the format-scan decoder.
    localparam int unsigned formatWidth = 4;
    localparam logic [formatWidth-1:0] formatI = 4'b0001;
    localparam logic [formatWidth-1:0] formatB = 4'b0010;
    localparam logic [formatWidth-1:0] formatD = 4'b0100;
    localparam logic [formatWidth-1:0] formatX = 4'b1000;

    // Byte address of a slot inside a block (fixed 4-byte instructions).
    function automatic logic [addressWidth-1:0] slotAddress(
        input logic [addressWidth-1:0] base,
        input int unsigned             slot
    );
        return base + addressWidth'(slot * 4);
    endfunction

endpackage

// File: rtl/fetch_issue_queue_if.sv
// Fetch-side and issue-side signals of the fetch issue queue.
// master: the queue (consumes fetch blocks, drives issue outputs).
// slave : the environment (fetch unit + decoder).
interface fetch_issue_queue_if;
    import fetch_issue_queue_pkg::*;

    logic                               fetchValid_i;
    logic [fetchBlockWidth-1:0]         fetchBlock_i;
    logic [addressWidth-1:0]            fetchAddress_i;
    logic [1:0]                         fetchStartSlot_i;
    logic [PidSize-1:0]                 fetchPid_i;
    logic [TidSize-1:0]                 fetchTid_i;
    logic                               fetchReady_o;
    logic                               stall_i;
    logic                               enable_o;
    logic [instructionWidth-1:0]        instruction_o;
    logic [addressWidth-1:0]            instructionAddress_o;
    logic [PidSize-1:0]                 instructionPid_o;
    logic [TidSize-1:0]                 instructionTid_o;
    logic [instructionCounterWidth-1:0] instructionMajId_o;

    modport master (
        input  fetchValid_i, fetchBlock_i, fetchAddress_i, fetchStartSlot_i,
               fetchPid_i, fetchTid_i, stall_i,
        output fetchReady_o, enable_o, instruction_o, instructionAddress_o,
               instructionPid_o, instructionTid_o, instructionMajId_o
    );

    modport slave (
        output fetchValid_i, fetchBlock_i, fetchAddress_i, fetchStartSlot_i,
               fetchPid_i, fetchTid_i, stall_i,
        input  fetchReady_o, enable_o, instruction_o, instructionAddress_o,
               instructionPid_o, instructionTid_o, instructionMajId_o
    );

endinterface

// File: rtl/issue_queue_ram.sv
// Issue queue storage: queueDepth entries, one write port per fetch slot,
// one combinational read port indexed by the head pointer.
// Ports: clock_i, writeEnable/writeIndex/writeData (per slot),
//        readIndex, readData_c (combinational).
module issue_queue_ram
    import fetch_issue_queue_pkg::*;
(
    input  logic                      clock_i,
    input  logic [fetchBlockSize-1:0] writeEnable,
    input  logic [ptrWidth-1:0]       writeIndex [fetchBlockSize],
    input  queueEntry_t               writeData  [fetchBlockSize],
    input  logic [ptrWidth-1:0]       readIndex,
    output queueEntry_t               readData_c
);

    queueEntry_t mem [queueDepth];

    // Enabled ports always target distinct entries, so order is irrelevant.
    always_ff @(posedge clock_i) begin
        for (int p = 0; p < int'(fetchBlockSize); p++) begin
            if (writeEnable[p]) begin
                mem[writeIndex[p]] <= writeData[p];
            end
        end
    end

    assign readData_c = mem[readIndex];

endmodule

// File: rtl/fetch_issue_queue.sv
// Fetch issue queue: buffers 4-instruction fetch blocks in a circular queue
// and issues one instruction per cycle with address, PID, TID and major ID.
// Ports: clock_i, reset_i (sync, active low), flush_i, bus (master modport:
//        fetch block input / fetchReady_o, stall_i / registered issue outputs).
module fetch_issue_queue
    import fetch_issue_queue_pkg::*;
(
    input  logic                clock_i,
    input  logic                reset_i,
    input  logic                flush_i,
    fetch_issue_queue_if.master bus
);

    logic [ptrWidth-1:0]                headPtr, headNext;
    logic [ptrWidth-1:0]                tailPtr, tailNext;
    logic [countWidth-1:0]              count, countNext;
    logic [instructionCounterWidth-1:0] majCounter, majCounterNext;
    logic [instructionCounterWidth-1:0] majOut, majOutNext;
    queueEntry_t                        outEntry, outEntryNext;
    logic                               enableOut, enableNext;
    logic                               readyOut, readyNext;

    logic [countWidth-1:0]              pushLen;
    logic                               pushAccept;
    logic                               popAccept;
    logic [fetchBlockSize-1:0]          writeEnable;
    logic [ptrWidth-1:0]                writeIndex [fetchBlockSize];
    queueEntry_t                        writeData  [fetchBlockSize];
    queueEntry_t                        readEntry_c;

    // Handshake qualification; a block is only taken while ready was advertised.
    always_comb begin
        pushLen    = countWidth'(fetchBlockSize) - countWidth'(bus.fetchStartSlot_i);
        pushAccept = bus.fetchValid_i && readyOut && !flush_i;
        popAccept  = !bus.stall_i && !flush_i && (count != '0);
    end

    // Slot s lands at tail + (s - startSlot); slots before startSlot are dropped.
    always_comb begin
        for (int s = 0; s < int'(fetchBlockSize); s++) begin
            writeEnable[s] = pushAccept && (2'(s) >= bus.fetchStartSlot_i);
            writeIndex[s]  = tailPtr + ptrWidth'(s) - ptrWidth'(bus.fetchStartSlot_i);
            writeData[s]   = '{
                instruction: bus.fetchBlock_i[(int'(fetchBlockSize) - 1 - s) * int'(instructionWidth) +: instructionWidth],
                address:     slotAddress(bus.fetchAddress_i, s),
                pid:         bus.fetchPid_i,
                tid:         bus.fetchTid_i
            };
        end
    end

    issue_queue_ram u_ram (
        .clock_i     (clock_i),
        .writeEnable (writeEnable),
        .writeIndex  (writeIndex),
        .writeData   (writeData),
        .readIndex   (headPtr),
        .readData_c  (readEntry_c)
    );

    // Next-state for pointers, count, major-ID counter and issue outputs.
    always_comb begin
        headNext       = headPtr;
        tailNext       = tailPtr;
        countNext      = count;
        majCounterNext = majCounter;
        majOutNext     = majOut;
        outEntryNext   = outEntry;
        enableNext     = enableOut;
        if (flush_i) begin
            headNext   = '0;
            tailNext   = '0;
            countNext  = '0;
            enableNext = 1'b0;
        end else begin
            if (popAccept) begin
                headNext       = headPtr + ptrWidth'(1);
                majCounterNext = majCounter + instructionCounterWidth'(1);
                majOutNext     = majCounter;
                outEntryNext   = readEntry_c;
                enableNext     = 1'b1;
            end else if (!bus.stall_i) begin
                enableNext = 1'b0;
            end
            if (pushAccept) begin
                tailNext = tailPtr + ptrWidth'(pushLen);
            end
            countNext = count + (pushAccept ? pushLen : '0)
                              - (popAccept ? countWidth'(1) : '0);
        end
        readyNext = (countWidth'(queueDepth) - countNext) >= countWidth'(fetchBlockSize);
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            headPtr    <= '0;
            tailPtr    <= '0;
            count      <= '0;
            majCounter <= '0;
            majOut     <= '0;
            outEntry   <= '0;
            enableOut  <= 1'b0;
            readyOut   <= 1'b1;
        end else begin
            headPtr    <= headNext;
            tailPtr    <= tailNext;
            count      <= countNext;
            majCounter <= majCounterNext;
            majOut     <= majOutNext;
            outEntry   <= outEntryNext;
            enableOut  <= enableNext;
            readyOut   <= readyNext;
        end
    end

    assign bus.fetchReady_o         = readyOut;
    assign bus.enable_o             = enableOut;
    assign bus.instruction_o        = outEntry.instruction;
    assign bus.instructionAddress_o = outEntry.address;
    assign bus.instructionPid_o     = outEntry.pid;
    assign bus.instructionTid_o     = outEntry.tid;
    assign bus.instructionMajId_o   = majOut;

endmodule
